// File: rtl/flop_compare_scoreboard.sv
// Purpose : accumulates a run verdict over per-sample check vectors (pass/fail, stats, first failure).
// Latency : every statistic reflects a sample one cycle after it is presented; done rises the cycle after the last sample.
// Backpr. : none; a sample is accepted on every cycle in RUN, and samples outside RUN are dropped.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   start               begin a new run (honoured in IDLE or DONE only)
//   sample, ok          per-sample strobe and check vector (bit i passes only when exactly 1)
//   stop_on_fail        finish the run at the first failing sample
//   busy, done, pass    run status; pass is meaningful only while done=1
//   fail_seen, fail_mask, first_fail_idx, first_fail_cyc, mismatch_cnt, sample_cnt  run statistics
module flop_compare_scoreboard #(
    parameter int NCHK   = 38,
    parameter int IDXW   = 6,
    parameter int CNTW   = 16,
    parameter int CYCW   = 32,
    parameter int RUNLEN = 33333
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            sample,
    input  logic [NCHK-1:0] ok,
    input  logic            stop_on_fail,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            fail_seen,
    output logic [NCHK-1:0] fail_mask,
    output logic [IDXW-1:0] first_fail_idx,
    output logic [CYCW-1:0] first_fail_cyc,
    output logic [CNTW-1:0] mismatch_cnt,
    output logic [CYCW-1:0] sample_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CYCW-1:0] RUNLEN_C = CYCW'(RUNLEN);

    state_t          state_q, state_d;
    logic            fail_seen_q, fail_seen_d;
    logic [NCHK-1:0] fail_mask_q, fail_mask_d;
    logic [IDXW-1:0] first_idx_q, first_idx_d;
    logic [CYCW-1:0] first_cyc_q, first_cyc_d;
    logic [CNTW-1:0] mis_cnt_q, mis_cnt_d;
    logic [CYCW-1:0] smp_cnt_q, smp_cnt_d;

    logic [NCHK-1:0] bit_fail;
    logic            any_fail;
    logic [IDXW-1:0] low_fail_idx;
    logic [CYCW-1:0] smp_cnt_inc;

    // X or Z on a check bit is a failure, not a pass.
    always_comb begin
        bit_fail = '0;
        for (int i = 0; i < NCHK; i++) begin
            bit_fail[i] = (ok[i] !== 1'b1);
        end
    end

    assign any_fail = |bit_fail;

    // Scan from the top so the last assignment wins with the lowest index.
    always_comb begin
        low_fail_idx = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (bit_fail[i]) begin
                low_fail_idx = IDXW'(i);
            end
        end
    end

    assign smp_cnt_inc = smp_cnt_q + CYCW'(1);

    always_comb begin
        state_d     = state_q;
        fail_seen_d = fail_seen_q;
        fail_mask_d = fail_mask_q;
        first_idx_d = first_idx_q;
        first_cyc_d = first_cyc_q;
        mis_cnt_d   = mis_cnt_q;
        smp_cnt_d   = smp_cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    fail_seen_d = 1'b0;
                    fail_mask_d = '0;
                    first_idx_d = '0;
                    first_cyc_d = '0;
                    mis_cnt_d   = '0;
                    smp_cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (sample) begin
                    smp_cnt_d = smp_cnt_inc;
                    if (any_fail) begin
                        fail_mask_d = fail_mask_q | bit_fail;
                        if (mis_cnt_q != '1) begin
                            mis_cnt_d = mis_cnt_q + CNTW'(1);
                        end
                        // Only the first failing sample of a run is captured.
                        if (!fail_seen_q) begin
                            fail_seen_d = 1'b1;
                            first_cyc_d = smp_cnt_q;
                            first_idx_d = low_fail_idx;
                        end
                    end
                    if ((smp_cnt_inc == RUNLEN_C) || (stop_on_fail && any_fail)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fail_seen_q <= 1'b0;
            fail_mask_q <= '0;
            first_idx_q <= '0;
            first_cyc_q <= '0;
            mis_cnt_q   <= '0;
            smp_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            fail_seen_q <= fail_seen_d;
            fail_mask_q <= fail_mask_d;
            first_idx_q <= first_idx_d;
            first_cyc_q <= first_cyc_d;
            mis_cnt_q   <= mis_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
        end
    end

    assign busy           = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign pass           = (state_q == ST_DONE) && !fail_seen_q;
    assign fail_seen      = fail_seen_q;
    assign fail_mask      = fail_mask_q;
    assign first_fail_idx = first_idx_q;
    assign first_fail_cyc = first_cyc_q;
    assign mismatch_cnt   = mis_cnt_q;
    assign sample_cnt     = smp_cnt_q;

endmodule

// File: tb/tb_flop_compare_scoreboard.sv
module tb_flop_compare_scoreboard;

    localparam int NCHK = 38;
    localparam int IDXW = 6;
    localparam int CYCW = 32;
    localparam int RLEN = 8;

    logic            clk = 1'b0;
    logic            rst_n, start, sample, stop_on_fail;
    logic [NCHK-1:0] ok;

    logic            busy, done, pass, fail_seen;
    logic [NCHK-1:0] fail_mask;
    logic [IDXW-1:0] first_fail_idx;
    logic [CYCW-1:0] first_fail_cyc, sample_cnt;
    logic [15:0]     mismatch_cnt;

    logic            s_busy, s_done, s_pass, s_fail_seen;
    logic [NCHK-1:0] s_fail_mask;
    logic [IDXW-1:0] s_first_fail_idx;
    logic [CYCW-1:0] s_first_fail_cyc, s_sample_cnt;
    logic [1:0]      s_mismatch_cnt;

    always #5 clk = ~clk;

    flop_compare_scoreboard #(.NCHK(NCHK), .IDXW(IDXW), .CNTW(16), .CYCW(CYCW), .RUNLEN(RLEN)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sample(sample), .ok(ok), .stop_on_fail(stop_on_fail),
        .busy(busy), .done(done), .pass(pass), .fail_seen(fail_seen), .fail_mask(fail_mask),
        .first_fail_idx(first_fail_idx), .first_fail_cyc(first_fail_cyc),
        .mismatch_cnt(mismatch_cnt), .sample_cnt(sample_cnt)
    );

    // Same stimulus into a 2-bit mismatch counter to observe saturation.
    flop_compare_scoreboard #(.NCHK(NCHK), .IDXW(IDXW), .CNTW(2), .CYCW(CYCW), .RUNLEN(RLEN)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .sample(sample), .ok(ok), .stop_on_fail(stop_on_fail),
        .busy(s_busy), .done(s_done), .pass(s_pass), .fail_seen(s_fail_seen), .fail_mask(s_fail_mask),
        .first_fail_idx(s_first_fail_idx), .first_fail_cyc(s_first_fail_cyc),
        .mismatch_cnt(s_mismatch_cnt), .sample_cnt(s_sample_cnt)
    );

    typedef struct {
        logic            busy, done, pass, fs;
        logic [NCHK-1:0] mask;
        logic [IDXW-1:0] ffi;
        logic [CYCW-1:0] ffc, scnt;
        logic [15:0]     mcnt;
        logic [1:0]      mcnt_sat;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state, kept in terms of the run semantics.
    int              m_state;   // 0 idle, 1 run, 2 done
    int              m_scnt, m_mcnt, m_ffi, m_ffc;
    logic            m_fs;
    logic [NCHK-1:0] m_mask;

    `define CHK(tag, obs, expv) \
        checks++; \
        assert ((obs) === (expv)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (expv)); \
        end

    task automatic model_clear();
        m_scnt = 0; m_mcnt = 0; m_ffi = 0; m_ffc = 0; m_fs = 1'b0; m_mask = '0;
    endtask

    task automatic push_expected();
        exp_t e;
        e.busy     = (m_state == 1);
        e.done     = (m_state == 2);
        e.pass     = (m_state == 2) && !m_fs;
        e.fs       = m_fs;
        e.mask     = m_mask;
        e.ffi      = IDXW'(m_ffi);
        e.ffc      = CYCW'(m_ffc);
        e.scnt     = CYCW'(m_scnt);
        e.mcnt     = 16'((m_mcnt > 65535) ? 65535 : m_mcnt);
        e.mcnt_sat = 2'((m_mcnt > 3) ? 3 : m_mcnt);
        exp_q.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL queue_empty observed=%0d expected=%0d", exp_q.size(), 1);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            `CHK("busy", busy, e.busy)
            `CHK("done", done, e.done)
            `CHK("pass", pass, e.pass)
            `CHK("fail_seen", fail_seen, e.fs)
            `CHK("fail_mask", fail_mask, e.mask)
            `CHK("first_fail_idx", first_fail_idx, e.ffi)
            `CHK("first_fail_cyc", first_fail_cyc, e.ffc)
            `CHK("mismatch_cnt", mismatch_cnt, e.mcnt)
            `CHK("sample_cnt", sample_cnt, e.scnt)
            `CHK("sat_busy", s_busy, e.busy)
            `CHK("sat_done", s_done, e.done)
            `CHK("sat_pass", s_pass, e.pass)
            `CHK("sat_fail_seen", s_fail_seen, e.fs)
            `CHK("sat_fail_mask", s_fail_mask, e.mask)
            `CHK("sat_first_fail_idx", s_first_fail_idx, e.ffi)
            `CHK("sat_first_fail_cyc", s_first_fail_cyc, e.ffc)
            `CHK("sat_mismatch_cnt", s_mismatch_cnt, e.mcnt_sat)
            `CHK("sat_sample_cnt", s_sample_cnt, e.scnt)
        end
    endtask

    // One clock of stimulus: drive, predict, clock, compare.
    task automatic step(input logic st, input logic smp, input logic [NCHK-1:0] okv, input logic sof);
        logic [NCHK-1:0] bf;
        logic            anyf;
        int              low;
        start = st; sample = smp; ok = okv; stop_on_fail = sof;
        bf = '0; low = -1;
        for (int i = 0; i < NCHK; i++) begin
            bf[i] = (okv[i] !== 1'b1);
            if (bf[i] && low < 0) low = i;
        end
        anyf = (low >= 0);
        if (m_state != 1) begin
            if (st) begin
                m_state = 1;
                model_clear();
            end
        end else if (smp) begin
            if (anyf) begin
                m_mcnt++;
                m_mask = m_mask | bf;
                if (!m_fs) begin
                    m_fs  = 1'b1;
                    m_ffc = m_scnt;
                    m_ffi = low;
                end
            end
            m_scnt++;
            if (m_scnt == RLEN || (sof && anyf)) m_state = 2;
        end
        push_expected();
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; sample = 1'b0; ok = '1; stop_on_fail = 1'b0;
        m_state = 0;
        model_clear();
        push_expected();
        @(posedge clk);
        #1;
        pop_compare();
        rst_n = 1'b1;
    endtask

    logic [NCHK-1:0] all1, v;

    initial begin
        all1 = '1;
        rst_n = 1'b1; start = 1'b0; sample = 1'b0; ok = '1; stop_on_fail = 1'b0;
        m_state = 0;
        model_clear();
        do_reset();
        `CHK("reset_done", done, 1'b0)
        `CHK("reset_pass", pass, 1'b0)
        `CHK("reset_sample_cnt", sample_cnt, 32'd0)

        // Samples while idle are ignored.
        step(1'b0, 1'b1, '0, 1'b0);
        `CHK("idle_ignores_sample", sample_cnt, 32'd0)

        // 1: clean run of RUNLEN samples.
        step(1'b1, 1'b0, all1, 1'b0);
        for (int k = 0; k < RLEN; k++) step(1'b0, 1'b1, all1, 1'b0);
        `CHK("t1_done", done, 1'b1)
        `CHK("t1_pass", pass, 1'b1)
        `CHK("t1_sample_cnt", sample_cnt, 32'd8)
        `CHK("t1_mismatch_cnt", mismatch_cnt, 16'd0)
        `CHK("t1_fail_mask", fail_mask, 38'd0)
        step(1'b0, 1'b1, '0, 1'b0);
        `CHK("t1_done_ignores_sample", sample_cnt, 32'd8)

        // 2: two failing samples, run continues to completion.
        step(1'b1, 1'b0, all1, 1'b0);
        `CHK("t2_done_drops", done, 1'b0)
        for (int k = 0; k < RLEN; k++) begin
            v = all1;
            if (k == 2) v[5] = 1'b0;
            if (k == 6) v[3] = 1'b0;
            step(1'b0, 1'b1, v, 1'b0);
        end
        `CHK("t2_fail_seen", fail_seen, 1'b1)
        `CHK("t2_first_fail_idx", first_fail_idx, 6'd5)
        `CHK("t2_first_fail_cyc", first_fail_cyc, 32'd2)
        `CHK("t2_mismatch_cnt", mismatch_cnt, 16'd2)
        `CHK("t2_fail_mask", fail_mask, 38'h28)
        `CHK("t2_pass", pass, 1'b0)
        `CHK("t2_done", done, 1'b1)

        // 3: stop on first failure, X counts as a failure.
        step(1'b1, 1'b0, all1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            v = all1;
            if (k == 4) begin
                v[7] = 1'bx;
                v[9] = 1'b0;
            end
            step(1'b0, 1'b1, v, 1'b1);
        end
        `CHK("t3_done", done, 1'b1)
        `CHK("t3_sample_cnt", sample_cnt, 32'd5)
        `CHK("t3_first_fail_idx", first_fail_idx, 6'd7)
        `CHK("t3_first_fail_cyc", first_fail_cyc, 32'd4)
        step(1'b0, 1'b1, '0, 1'b1);
        step(1'b0, 1'b1, '0, 1'b1);
        `CHK("t3_later_ignored", sample_cnt, 32'd5)

        // 4: every sample fails; 2-bit counter saturates.
        step(1'b1, 1'b0, all1, 1'b0);
        for (int k = 0; k < RLEN; k++) step(1'b0, 1'b1, '0, 1'b0);
        `CHK("t4_sat_mismatch", s_mismatch_cnt, 2'd3)
        `CHK("t4_full_mismatch", mismatch_cnt, 16'd8)
        `CHK("t4_sample_cnt", s_sample_cnt, 32'd8)
        `CHK("t4_first_fail_idx", first_fail_idx, 6'd0)

        // 5: sparse samples with start pulsed mid-run.
        step(1'b1, 1'b0, all1, 1'b0);
        for (int k = 0; k < RLEN; k++) begin
            step(1'b0, 1'b1, all1, 1'b0);
            step(k == 2, 1'b0, all1, 1'b0);
            if (k != RLEN - 1) begin
                `CHK("t5_not_done", done, 1'b0)
            end
            step(k == 5, 1'b0, all1, 1'b0);
        end
        `CHK("t5_done", done, 1'b1)
        `CHK("t5_sample_cnt", sample_cnt, 32'd8)
        `CHK("t5_pass", pass, 1'b1)

        // 6: reset mid-run, then a clean run.
        step(1'b1, 1'b0, all1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            v = all1;
            if (k == 1) v[20] = 1'b0;
            step(1'b0, 1'b1, v, 1'b0);
        end
        `CHK("t6_pre_fail_seen", fail_seen, 1'b1)
        do_reset();
        `CHK("t6_busy", busy, 1'b0)
        `CHK("t6_fail_seen", fail_seen, 1'b0)
        `CHK("t6_fail_mask", fail_mask, 38'd0)
        `CHK("t6_mismatch_cnt", mismatch_cnt, 16'd0)
        `CHK("t6_sample_cnt", sample_cnt, 32'd0)
        step(1'b1, 1'b0, all1, 1'b0);
        for (int k = 0; k < RLEN; k++) step(1'b0, 1'b1, all1, 1'b0);
        `CHK("t6_clean_pass", pass, 1'b1)
        `CHK("t6_clean_done", done, 1'b1)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
